axis_video_pattern_gen: RTL

//   AXI4-Stream video master that transmits the input video stream the Keystone block consumes.

---
 rtl/axis_video_pattern_gen_pkg.sv | 39 +++
 rtl/axis_video_pattern_gen_if.sv | 15 +
 rtl/axis_video_pattern_rgb.sv | 61 ++++++
 rtl/axis_video_pattern_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pattern_gen_pkg.sv
// Shared video types for the pattern generator and the Keystone receiver.
//   rgb_t      : 8-bit-per-channel pixel colour {r,g,b}
//   pattern_e  : test pattern selector
//   state_e    : generator frame sequencing state
//   pack_pixel : places an rgb_t into the AXI4-Stream tdata word
//                (G at [9:2], B at [19:12], R at [29:22], all other bits 0)
package keystone_video_pkg;

    localparam int TDATA_W = 64;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PAT_RAMP    = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_SOLID   = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    function automatic logic [TDATA_W-1:0] pack_pixel(input rgb_t px);
        logic [TDATA_W-1:0] w;
        w        = '0;
        w[9:2]   = px.g;
        w[19:12] = px.b;
        w[29:22] = px.r;
        return w;
    endfunction

endpackage

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus (tdata/tvalid/tready/tuser=SOF/tlast=EOL).
//   master modport: drives tdata, tvalid, tuser, tlast; receives tready
//   slave modport : the mirror image
interface axis_video_pattern_gen_if #(
    parameter int TDATA_W = 64
) ();
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tuser;
    logic               tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_video_pattern_rgb.sv
// Combinational pixel colour generator.
//   pattern : selected test pattern
//   x, y    : pixel coordinates
//   solid   : colour for the solid pattern
//   rgb     : resulting colour (registered into tdata by the parent)
module axis_video_pattern_rgb
    import keystone_video_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int X_W      = 11,
    parameter int Y_W      = 11
) (
    input  pattern_e         pattern,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  rgb_t             solid,
    output rgb_t             rgb
);
    // Guard against a zero divisor for very narrow test frames.
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [31:0] x_ext;
    logic [31:0] bar;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic [3:0]  y4;

    always_comb begin
        x_ext = 32'(x);
        x8    = 8'(x);
        y8    = 8'(y);
        y4    = 4'(y);
        bar   = x_ext / 32'(BAR_W);
        rgb   = '0;
        case (pattern)
            PAT_RAMP: begin
                rgb.r = x8;
                rgb.g = y8;
                rgb.b = x8 + y8;
            end
            PAT_BARS: begin
                // Pixels past the eighth bar (remainder) stay black.
                if (bar < 32'd8) begin
                    case (bar[2:0])
                        3'd0:    rgb = rgb_t'(24'hFFFFFF);
                        3'd1:    rgb = rgb_t'(24'hFFFF00);
                        3'd2:    rgb = rgb_t'(24'h00FFFF);
                        3'd3:    rgb = rgb_t'(24'h00FF00);
                        3'd4:    rgb = rgb_t'(24'hFF00FF);
                        3'd5:    rgb = rgb_t'(24'hFF0000);
                        3'd6:    rgb = rgb_t'(24'h0000FF);
                        default: rgb = rgb_t'(24'h000000);
                    endcase
                end
            end
            PAT_SOLID: rgb = solid;
            default: rgb = (x_ext[3] ^ y4[3]) ? rgb_t'(24'hFFFFFF) : rgb_t'(24'h000000);
        endcase
    end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video pattern master: emits full frames of synthetic pixels
// with SOF on tuser and EOL on tlast, honouring tready backpressure.
//   aclk, aresetn    : clock, asynchronous active-low reset
//   aclken           : clock enable, low freezes all state and outputs
//   enable           : start/continue frames (sampled at frame boundaries)
//   pattern_sel      : 0 ramp, 1 colour bars, 2 solid, 3 checker
//   solid_rgb        : {R,G,B} for the solid pattern
//   m_axis_video     : AXI4-Stream master bus
//   frame_done       : one-cycle pulse when the last pixel of a frame transfers
//   frame_count      : completed frames, wrapping
//
// state     | meaning
// ST_IDLE   | no frame in progress, waiting for enable
// ST_ACTIVE | presenting pixels, tvalid=1
// ST_GAP    | inter-frame idle, tvalid=0 for FRAME_GAP enabled cycles
module axis_video_pattern_gen
    import keystone_video_pkg::*;
#(
    parameter int H_ACTIVE  = 1920,
    parameter int V_ACTIVE  = 1080,
    parameter int FRAME_GAP = 16,
    parameter int TDATA_W   = keystone_video_pkg::TDATA_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     aclken,
    input  logic                     enable,
    input  logic [1:0]               pattern_sel,
    input  logic [23:0]              solid_rgb,
    axis_video_pattern_gen_if.master m_axis_video,
    output logic                     frame_done,
    output logic [15:0]              frame_count
);
    localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    pattern_e           pat_q, pat_d;
    rgb_t               solid_q, solid_d;
    logic [TDATA_W-1:0] tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tuser_q, tuser_d;
    logic               tlast_q, tlast_d;
    logic               frame_done_q, frame_done_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               xfer;
    logic               load_pix;
    logic               start_frame;
    rgb_t               pix_rgb;

    // Colour is computed from the *next* coordinates and pattern so the
    // pixel lands in tdata on the same edge the counters advance.
    axis_video_pattern_rgb #(
        .H_ACTIVE (H_ACTIVE),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_rgb (
        .pattern (pat_d),
        .x       (x_d),
        .y       (y_d),
        .solid   (solid_d),
        .rgb     (pix_rgb)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        gap_d         = gap_q;
        pat_d         = pat_q;
        solid_d       = solid_q;
        tvalid_d      = tvalid_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        load_pix      = 1'b0;
        start_frame   = 1'b0;
        xfer          = tvalid_q & m_axis_video.tready;

        case (state_q)
            ST_IDLE: begin
                if (enable) start_frame = 1'b1;
            end
            ST_ACTIVE: begin
                if (xfer) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d           = '0;
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count_q + 16'd1;
                            if (FRAME_GAP > 0) begin
                                state_d  = ST_GAP;
                                gap_d    = GAP_LOAD;
                                tvalid_d = 1'b0;
                            end else if (enable) begin
                                start_frame = 1'b1;
                            end else begin
                                state_d  = ST_IDLE;
                                tvalid_d = 1'b0;
                            end
                        end else begin
                            y_d      = y_q + Y_W'(1);
                            load_pix = 1'b1;
                        end
                    end else begin
                        x_d      = x_q + X_W'(1);
                        load_pix = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    if (enable) start_frame = 1'b1;
                    else        state_d     = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
            end
        endcase

        // Every entry into ACTIVE latches the pattern for the whole frame.
        if (start_frame) begin
            state_d  = ST_ACTIVE;
            x_d      = '0;
            y_d      = '0;
            pat_d    = pattern_e'(pattern_sel);
            solid_d  = rgb_t'(solid_rgb);
            tvalid_d = 1'b1;
            load_pix = 1'b1;
        end
    end

    always_comb begin
        tdata_d = tdata_q;
        tuser_d = tuser_q;
        tlast_d = tlast_q;
        if (load_pix) begin
            tdata_d = TDATA_W'(pack_pixel(pix_rgb));
            tuser_d = (x_d == '0) && (y_d == '0);
            tlast_d = (x_d == X_LAST);
        end else if (!tvalid_d) begin
            tdata_d = '0;
            tuser_d = 1'b0;
            tlast_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            gap_q         <= '0;
            pat_q         <= PAT_RAMP;
            solid_q       <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tuser_q       <= 1'b0;
            tlast_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else if (aclken) begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            gap_q         <= gap_d;
            pat_q         <= pat_d;
            solid_q       <= solid_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tuser_q       <= tuser_d;
            tlast_q       <= tlast_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_axis_video.tdata  = tdata_q;
    assign m_axis_video.tvalid = tvalid_q;
    assign m_axis_video.tuser  = tuser_q;
    assign m_axis_video.tlast  = tlast_q;
    assign frame_done          = frame_done_q;
    assign frame_count         = frame_count_q;

endmodule
